// File: rtl/iir_sos_engine_pkg.sv
// Shared definitions for the time-multiplexed biquad cascade.
// Provides the datapath widths, section/tap counts, Q2.22 saturation limits,
// the FSM state encoding and a sign-extension helper for products.
package iir_sos_engine_pkg;

  localparam int unsigned DW           = 24;  // sample / coefficient width, Q2.22
  localparam int unsigned FRAC         = 22;  // fractional bits
  localparam int unsigned NSEC         = 4;   // cascaded sections
  localparam int unsigned ACCW         = 52;  // 48-bit product + 4 guard bits
  localparam int unsigned COEF_PER_SEC = 5;   // b0 b1 b2 a1 a2
  localparam int unsigned PW           = 2 * DW;
  localparam int unsigned AW           = 5;   // coefficient ROM address width
  localparam int unsigned SW           = $clog2(NSEC);
  localparam int unsigned TW           = 3;   // tap counter width

  localparam logic [SW-1:0] LastSec = SW'(NSEC - 1);
  localparam logic [TW-1:0] LastTap = TW'(COEF_PER_SEC - 1);

  localparam logic signed [DW-1:0] SatMax = {1'b0, {(DW - 1){1'b1}}};  // 0x7FFFFF
  localparam logic signed [DW-1:0] SatMin = {1'b1, {(DW - 1){1'b0}}};  // 0x800000

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StFin,
    StOut
  } state_e;

  function automatic logic signed [ACCW-1:0] sext_prod(input logic signed [PW-1:0] p);
    return {{(ACCW - PW){p[PW-1]}}, p};
  endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Converts a section accumulator back to a Q2.22 sample.
// Round half up (add 2^(FRAC-1)), arithmetic shift right by FRAC, then clamp
// to the signed DW-bit range.
//   acc_i  : accumulator, signed, ACCW bits, 2*FRAC fractional bits
//   data_o : rounded/saturated Q2.22 sample
//   sat_o  : high when clamping occurred
module iir_round_sat
  import iir_sos_engine_pkg::*;
(
  input  logic [ACCW-1:0] acc_i,
  output logic [DW-1:0]   data_o,
  output logic            sat_o
);

  localparam logic signed [ACCW-1:0] Half =
    {{(ACCW - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
  localparam logic signed [ACCW-1:0] MaxExt = {{(ACCW - DW){1'b0}}, SatMax};
  localparam logic signed [ACCW-1:0] MinExt = {{(ACCW - DW){1'b1}}, SatMin};

  logic signed [ACCW-1:0] rounded;
  logic signed [ACCW-1:0] shifted;

  always_comb begin
    rounded = $signed(acc_i) + Half;
    shifted = rounded >>> FRAC;
    data_o  = shifted[DW-1:0];
    sat_o   = 1'b0;
    if (shifted > MaxExt) begin
      data_o = SatMax;
      sat_o  = 1'b1;
    end else if (shifted < MinExt) begin
      data_o = SatMin;
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/iir_sos_engine.sv
// Time-multiplexed 4-section DF-I biquad cascade sharing one 24x24 multiplier.
// One sample in, 5 MAC cycles + 1 finish cycle per section, one sample out.
//   clk_i         : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   in_valid_i    : input sample valid
//   in_ready_o    : sample can be accepted (idle and no clear request)
//   in_data_i     : input sample, Q2.22
//   clear_state_i : zero all delay lines (idle only)
//   coeff_addr_o  : registered coefficient ROM address
//   coeff_in_i    : ROM data for coeff_addr_o, Q2.22
//   out_valid_o   : one-cycle pulse, out_data_o valid
//   out_data_o    : filtered sample, held until next out_valid_o
//   sat_flag_o    : pulse with out_valid_o if any section clamped
//   busy_o        : high from acceptance through the out_valid_o cycle
module iir_sos_engine
  import iir_sos_engine_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          clear_state_i,
  output logic [AW-1:0] coeff_addr_o,
  input  logic [DW-1:0] coeff_in_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          sat_flag_o,
  output logic          busy_o
);

  state_e state_q, state_d;

  logic [TW-1:0] tap_q, tap_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [AW-1:0] addr_q, addr_d;

  // x_q holds the current section input; d1/d2[k] is the input history of
  // section k, and d1/d2[k+1] doubles as its output history.
  logic signed [DW-1:0]   x_q, x_d;
  logic signed [DW-1:0]   d1_q [NSEC+1];
  logic signed [DW-1:0]   d1_d [NSEC+1];
  logic signed [DW-1:0]   d2_q [NSEC+1];
  logic signed [DW-1:0]   d2_d [NSEC+1];
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   sat_q, sat_d;
  logic [DW-1:0]          out_data_q, out_data_d;

  logic                   accept;
  logic [SW:0]            sec_up;
  logic signed [DW-1:0]   coef_s;
  logic signed [DW-1:0]   op;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic [DW-1:0]          y;
  logic                   y_sat;

  assign accept = in_valid_i && in_ready_o;
  assign sec_up = {1'b0, sec_q} + 1'b1;

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StMac;
      StMac:  if (tap_q == LastTap) state_d = StFin;
      StFin:  state_d = (sec_q == LastSec) ? StOut : StMac;
      StOut:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready_o  = (state_q == StIdle) && !clear_state_i;
    out_valid_o = (state_q == StOut);
    sat_flag_o  = (state_q == StOut) && sat_q;
    busy_o      = (state_q != StIdle) || accept;
  end

  // Shared multiplier: taps 0..2 use input history, taps 3..4 output history.
  assign coef_s = coeff_in_i;

  always_comb begin
    case (tap_q)
      3'd0:    op = x_q;
      3'd1:    op = d1_q[sec_q];
      3'd2:    op = d2_q[sec_q];
      3'd3:    op = d1_q[sec_up];
      3'd4:    op = d2_q[sec_up];
      default: op = '0;
    endcase
  end

  assign prod     = coef_s * op;
  assign prod_ext = sext_prod(prod);

  iir_round_sat u_round_sat (
    .acc_i  (acc_q),
    .data_o (y),
    .sat_o  (y_sat)
  );

  // Datapath next-state
  always_comb begin
    tap_d      = tap_q;
    sec_d      = sec_q;
    addr_d     = addr_q;
    x_d        = x_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (clear_state_i) begin
          for (int i = 0; i <= NSEC; i++) begin
            d1_d[i] = '0;
            d2_d[i] = '0;
          end
        end else if (accept) begin
          x_d    = in_data_i;
          sat_d  = 1'b0;
          tap_d  = '0;
          sec_d  = '0;
          addr_d = '0;
        end
      end
      StMac: begin
        // First tap restarts the accumulator; a-terms are subtracted.
        if (tap_q == '0) begin
          acc_d = prod_ext;
        end else if (tap_q >= 3'd3) begin
          acc_d = acc_q - prod_ext;
        end else begin
          acc_d = acc_q + prod_ext;
        end
        tap_d = (tap_q == LastTap) ? '0 : tap_q + 1'b1;
        if (tap_q == LastTap && sec_q == LastSec) begin
          addr_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StFin: begin
        d2_d[sec_q] = d1_q[sec_q];
        d1_d[sec_q] = x_q;
        if (sec_q == LastSec) begin
          d2_d[NSEC] = d1_q[NSEC];
          d1_d[NSEC] = y;
          out_data_d = y;
        end
        x_d   = y;
        sat_d = sat_q | y_sat;
        sec_d = sec_q + 1'b1;
      end
      StOut: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tap_q      <= '0;
      sec_q      <= '0;
      addr_q     <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      for (int i = 0; i <= NSEC; i++) begin
        d1_q[i] <= '0;
        d2_q[i] <= '0;
      end
    end else begin
      tap_q      <= tap_d;
      sec_q      <= sec_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
    end
  end

  assign coeff_addr_o = addr_q;
  assign out_data_o   = out_data_q;

endmodule
